// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (unpack / normalise / round-pack)
// with valid/ready back-pressure, round-to-nearest-even, DAZ/FTZ and exception flags.
module fp_mul_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         CLK,
   input  logic         RESETn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out,
   output logic [3:0]   flags
);

   localparam int PW   = 2 * MAN_W + 2;
   localparam int EW   = EXP_W + 2;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int EMAX = (1 << EXP_W) - 1;

   localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
   localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
   localparam logic signed [EW-1:0] ONE_S  = EW'(1);
   localparam logic signed [EW-1:0] ZERO_S = '0;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic adv;

   logic               valid1_q, special1_q, sign1_q;
   logic [W-1:0]       specRes1_q;
   logic [3:0]         specFlags1_q;
   logic signed [EW-1:0] eSum1_q;
   logic [PW-1:0]      prod1_q;

   logic               valid2_q, special2_q, sign2_q, guard2_q, sticky2_q;
   logic [W-1:0]       specRes2_q;
   logic [3:0]         specFlags2_q;
   logic signed [EW-1:0] e2_q;
   logic [MAN_W-1:0]   frac2_q;

   logic               outValid_q;
   logic [W-1:0]       out_q;
   logic [3:0]         flags_q;

   logic               special1_d, sign1_d;
   logic [W-1:0]       specRes1_d;
   logic [3:0]         specFlags1_d;
   logic signed [EW-1:0] eSum1_d;
   logic [PW-1:0]      prod1_d;

   logic signed [EW-1:0] e2_d;
   logic [MAN_W-1:0]   frac2_d;
   logic               guard2_d, sticky2_d;

   logic [W-1:0]       out_d;
   logic [3:0]         flags_d;

   logic [EXP_W-1:0]   expA, expB;
   logic [MAN_W-1:0]   fracA, fracB;
   logic               aZero, bZero, aInf, bInf, aNan, bNan;

   logic               roundUp, carry;
   logic [MAN_W-1:0]   fracR;
   logic signed [EW-1:0] eR;

   assign adv       = ~outValid_q | out_ready;
   assign in_ready  = adv;
   assign out_valid = outValid_q;
   assign out       = out_q;
   assign flags     = flags_q;

   assign expA  = A[W-2:MAN_W];
   assign expB  = B[W-2:MAN_W];
   assign fracA = A[MAN_W-1:0];
   assign fracB = B[MAN_W-1:0];
   assign aZero = (expA == '0);
   assign bZero = (expB == '0);
   assign aInf  = (expA == '1) && (fracA == '0);
   assign bInf  = (expB == '1) && (fracB == '0);
   assign aNan  = (expA == '1) && (fracA != '0);
   assign bNan  = (expB == '1) && (fracB != '0);

   // Stage 1: classify operands and start the arithmetic; specials are resolved here
   // and carried down so later stages only need a single override mux.
   always_comb begin
      sign1_d      = A[W-1] ^ B[W-1];
      special1_d   = 1'b0;
      specRes1_d   = '0;
      specFlags1_d = '0;
      if (aNan || bNan || (aInf && bZero) || (bInf && aZero)) begin
         special1_d   = 1'b1;
         specRes1_d   = QNAN;
         specFlags1_d = 4'b1000;
      end else if (aInf || bInf) begin
         special1_d   = 1'b1;
         specRes1_d   = {sign1_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (aZero || bZero) begin
         special1_d   = 1'b1;
         specRes1_d   = {sign1_d, {(W-1){1'b0}}};
      end
      eSum1_d = $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS_S;
      prod1_d = PW'({1'b1, fracA}) * PW'({1'b1, fracB});
   end

   // Stage 2: the product of two [1,2) mantissas lies in [1,4), so at most one shift.
   always_comb begin
      if (prod1_q[PW-1]) begin
         e2_d      = eSum1_q + ONE_S;
         frac2_d   = prod1_q[PW-2:MAN_W+1];
         guard2_d  = prod1_q[MAN_W];
         sticky2_d = |prod1_q[MAN_W-1:0];
      end else begin
         e2_d      = eSum1_q;
         frac2_d   = prod1_q[PW-3:MAN_W];
         guard2_d  = prod1_q[MAN_W-1];
         sticky2_d = |prod1_q[MAN_W-2:0];
      end
   end

   // Stage 3: round to nearest even, then range-check the final exponent.
   always_comb begin
      roundUp        = guard2_q & (sticky2_q | frac2_q[0]);
      {carry, fracR} = {1'b0, frac2_q} + (MAN_W+1)'(roundUp);
      eR             = carry ? (e2_q + ONE_S) : e2_q;
      if (special2_q) begin
         out_d   = specRes2_q;
         flags_d = specFlags2_q;
      end else if (eR >= EMAX_S) begin
         out_d   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d = 4'b0101;
      end else if (eR <= ZERO_S) begin
         out_d   = {sign2_q, {(W-1){1'b0}}};
         flags_d = 4'b0011;
      end else begin
         out_d   = {sign2_q, eR[EXP_W-1:0], fracR};
         flags_d = {3'b000, guard2_q | sticky2_q};
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         valid1_q     <= 1'b0;
         special1_q   <= 1'b0;
         sign1_q      <= 1'b0;
         specRes1_q   <= '0;
         specFlags1_q <= '0;
         eSum1_q      <= '0;
         prod1_q      <= '0;
         valid2_q     <= 1'b0;
         special2_q   <= 1'b0;
         sign2_q      <= 1'b0;
         specRes2_q   <= '0;
         specFlags2_q <= '0;
         e2_q         <= '0;
         frac2_q      <= '0;
         guard2_q     <= 1'b0;
         sticky2_q    <= 1'b0;
         outValid_q   <= 1'b0;
         out_q        <= '0;
         flags_q      <= '0;
      end else if (adv) begin
         valid1_q     <= in_valid;
         special1_q   <= special1_d;
         sign1_q      <= sign1_d;
         specRes1_q   <= specRes1_d;
         specFlags1_q <= specFlags1_d;
         eSum1_q      <= eSum1_d;
         prod1_q      <= prod1_d;
         valid2_q     <= valid1_q;
         special2_q   <= special1_q;
         sign2_q      <= sign1_q;
         specRes2_q   <= specRes1_q;
         specFlags2_q <= specFlags1_q;
         e2_q         <= e2_d;
         frac2_q      <= frac2_d;
         guard2_q     <= guard2_d;
         sticky2_q    <= sticky2_d;
         outValid_q   <= valid2_q;
         out_q        <= out_d;
         flags_q      <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe: fp16 instance for function,
// latency, reset and back-pressure; fp32 instance for the parameter sweep.
module tb_fp_mul_pipe;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b0;

   logic        inValid16, inReady16, outValid16, outReady16;
   logic [15:0] a16, b16, out16;
   logic [3:0]  flags16;

   logic        inValid32, inReady32, outValid32, outReady32;
   logic [31:0] a32, b32, out32;
   logic [3:0]  flags32;

   int testsRun  = 0;
   int failCount = 0;

   logic [15:0] sA   [5] = '{16'h3C00, 16'h3E00, 16'h3C01, 16'h7BFF, 16'hFC00};
   logic [15:0] sB   [5] = '{16'h4000, 16'h3E00, 16'h3C01, 16'h4000, 16'h4000};
   logic [15:0] sExp [5] = '{16'h4000, 16'h4080, 16'h3C02, 16'h7C00, 16'hFC00};
   logic [15:0] got [$];
   int          idx;
   logic        fire;
   logic        stall;

   fp_mul_pipe dut16 (
      .CLK(CLK), .RESETn(RESETn),
      .in_valid(inValid16), .in_ready(inReady16), .A(a16), .B(b16),
      .out_valid(outValid16), .out_ready(outReady16), .out(out16), .flags(flags16)
   );

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
      .CLK(CLK), .RESETn(RESETn),
      .in_valid(inValid32), .in_ready(inReady32), .A(a32), .B(b32),
      .out_valid(outValid32), .out_ready(outReady32), .out(out32), .flags(flags32)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One isolated operation on the fp16 instance, checking the 3-clock latency.
   task automatic applyStimulus16(input string tag, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] expOut, input logic [3:0] expFlags);
      @(negedge CLK);
      inValid16 = 1'b1; a16 = a; b16 = b; outReady16 = 1'b1;
      @(negedge CLK);
      inValid16 = 1'b0; a16 = '0; b16 = '0;
      @(negedge CLK);
      checkOutput({tag, "_early"}, 32'(outValid16), 32'd0);
      @(negedge CLK);
      checkOutput({tag, "_valid"}, 32'(outValid16), 32'd1);
      checkOutput({tag, "_out"},   32'(out16),      32'(expOut));
      checkOutput({tag, "_flags"}, 32'(flags16),    32'(expFlags));
   endtask

   task automatic applyStimulus32(input string tag, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] expOut, input logic [3:0] expFlags);
      @(negedge CLK);
      inValid32 = 1'b1; a32 = a; b32 = b; outReady32 = 1'b1;
      @(negedge CLK);
      inValid32 = 1'b0; a32 = '0; b32 = '0;
      @(negedge CLK);
      @(negedge CLK);
      checkOutput({tag, "_valid"}, 32'(outValid32), 32'd1);
      checkOutput({tag, "_out"},   out32,           expOut);
      checkOutput({tag, "_flags"}, 32'(flags32),    32'(expFlags));
   endtask

   initial begin
      inValid16 = 1'b1; a16 = 16'h3C00; b16 = 16'h4000; outReady16 = 1'b1;
      inValid32 = 1'b0; a32 = '0; b32 = '0; outReady32 = 1'b1;

      // Held in reset with a valid operand presented: nothing may emerge.
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         checkOutput("rst_valid", 32'(outValid16), 32'd0);
         checkOutput("rst_out",   32'(out16),      32'd0);
         checkOutput("rst_flags", 32'(flags16),    32'd0);
      end
      inValid16 = 1'b0;
      RESETn = 1'b1;
      #1;
      checkOutput("rst_ready", 32'(inReady16), 32'd1);

      applyStimulus16("one_x_two",   16'h3C00, 16'h4000, 16'h4000, 4'b0000);
      applyStimulus16("onehalf_sq",  16'h3E00, 16'h3E00, 16'h4080, 4'b0000);
      applyStimulus16("round",       16'h3C01, 16'h3C01, 16'h3C02, 4'b0001);
      applyStimulus16("underflow",   16'hA800, 16'h0C00, 16'h8000, 4'b0011);
      applyStimulus16("overflow",    16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
      applyStimulus16("inf_x_zero",  16'h7C00, 16'h0000, 16'h7E00, 4'b1000);
      applyStimulus16("neginf_x_2",  16'hFC00, 16'h4000, 16'hFC00, 4'b0000);
      applyStimulus16("nan_in",      16'h7E01, 16'h3C00, 16'h7E00, 4'b1000);
      applyStimulus16("zero_x_neg",  16'h0000, 16'hC000, 16'h8000, 4'b0000);

      // Mid-stream reset: fill the pipe, then drop reset and expect it empty.
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         inValid16 = 1'b1; a16 = 16'h3C00; b16 = 16'h4000;
      end
      @(negedge CLK);
      inValid16 = 1'b0;
      #1;
      RESETn = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(outValid16), 32'd0);
      checkOutput("midrst_out",   32'(out16),      32'd0);
      @(negedge CLK);
      RESETn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checkOutput("midrst_stale", 32'(outValid16), 32'd0);
      end

      // Back-to-back stream with out_ready dropped for cycles 4..7.
      idx = 0;
      for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
         @(negedge CLK);
         stall      = (cyc >= 4) && (cyc < 8);
         outReady16 = ~stall;
         inValid16  = (idx < 5);
         if (idx < 5) begin
            a16 = sA[idx]; b16 = sB[idx];
         end
         #1;
         if (stall) begin
            checkOutput("stall_ready", 32'(inReady16),  32'd0);
            checkOutput("stall_valid", 32'(outValid16), 32'd1);
            checkOutput("stall_hold",  32'(out16),      32'(sExp[got.size()]));
         end
         fire = inValid16 && inReady16;
         if (outValid16 && outReady16) got.push_back(out16);
         @(posedge CLK);
         if (fire) idx++;
      end
      inValid16 = 1'b0;
      checkOutput("stream_count", 32'(got.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         checkOutput($sformatf("stream_%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hxxxxxxxx,
                     32'(sExp[i]));
      @(negedge CLK);
      checkOutput("stream_drained", 32'(outValid16), 32'd0);

      applyStimulus32("fp32_one_x_two",  32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000);
      applyStimulus32("fp32_inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
